// File: rtl/hex_disp_pkg.sv
// Shared definitions for the hex display datapath: nibble width, default
// debounce length and the key debounce state encoding.
package hex_disp_pkg;

  localparam int unsigned NIBBLE_W                = 4;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;

  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } key_state_e;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus press/release FSM for an active-low pushbutton.
// HEX_STEP_DEBOUNCE_EN builds the stability counter; otherwise the FSM tracks the synced level.
module key_debounce
  import hex_disp_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic step
);

  logic       sync1_q;
  logic       sync2_q;
  key_state_e state_q;
  key_state_e state_d;
  logic       step_q;
  logic       step_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

`ifdef HEX_STEP_DEBOUNCE_EN
  localparam int unsigned       CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             differs;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    step_d  = 1'b0;
    // RELEASED rests at key_n=1, PRESSED at key_n=0
    differs = (sync2_q != (state_q == RELEASED));
    if (differs) begin
      if (cnt_q == CNT_LAST) begin
        state_d = (state_q == RELEASED) ? PRESSED : RELEASED;
        step_d  = (state_q == RELEASED);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
    end
  end
`else
  always_comb begin
    state_d = sync2_q ? RELEASED : PRESSED;
    step_d  = (state_q == RELEASED) && !sync2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RELEASED;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end
`endif

  assign step = step_q;

endmodule

// File: rtl/hex_step_counter.sv
// Debounced pushbutton stepping a DIGITS-wide hex up/down counter with load.
// Debounce filtering is enabled by HEX_STEP_DEBOUNCE_EN (see key_debounce).
module hex_step_counter
  import hex_disp_pkg::*;
#(
  parameter int unsigned DIGITS          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                         CLOCK_50,
  input  logic                         resetn,
  input  logic                         key_n,
  input  logic                         up,
  input  logic                         load,
  input  logic [NIBBLE_W*DIGITS-1:0]   load_value,
  output logic [NIBBLE_W*DIGITS-1:0]   count,
  output logic                         step,
  output logic                         wrap
);

  localparam int unsigned CW = NIBBLE_W * DIGITS;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          wrap_q;
  logic          wrap_d;
  logic          step_pulse;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk  (CLOCK_50),
    .rst_n(resetn),
    .key_n(key_n),
    .step (step_pulse)
  );

  // load wins over a coincident step, which is then lost
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = load_value;
    end else if (step_pulse) begin
      if (up) begin
        count_d = count_q + 1'b1;
        wrap_d  = &count_q;
      end else begin
        count_d = count_q - 1'b1;
        wrap_d  = ~|count_q;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign step  = step_pulse;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_hex_step_counter.sv
// Directed self-checking bench for hex_step_counter (DIGITS=4, DEBOUNCE_CYCLES=4).
// Timing expectations follow whether HEX_STEP_DEBOUNCE_EN is defined.
module tb_hex_step_counter;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned DC     = 4;
`ifdef HEX_STEP_DEBOUNCE_EN
  localparam int STEP_TICKS = DC + 2;
`else
  localparam int STEP_TICKS = 3;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        key_n;
  logic        up;
  logic        load;
  logic [15:0] load_value;
  logic [15:0] count;
  logic        step;
  logic        wrap;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_count;

  always #5 clk = ~clk;

  hex_step_counter #(
    .DIGITS         (DIGITS),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .CLOCK_50  (clk),
    .resetn    (resetn),
    .key_n     (key_n),
    .up        (up),
    .load      (load),
    .load_value(load_value),
    .count     (count),
    .step      (step),
    .wrap      (wrap)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic dir, input int hold, input logic [15:0] exp_c,
                       input logic exp_w, input string tag);
    int extra = 0;
    up    = dir;
    key_n = 1'b0;
    tick(STEP_TICKS - 1);
    chk({tag, "_step_early"}, {31'd0, step}, 32'd0);
    tick(1);
    chk({tag, "_step"}, {31'd0, step}, 32'd1);
    chk({tag, "_count_pre"}, {16'd0, count}, {16'd0, exp_count});
    tick(1);
    chk({tag, "_step_done"}, {31'd0, step}, 32'd0);
    chk({tag, "_count"}, {16'd0, count}, {16'd0, exp_c});
    chk({tag, "_wrap"}, {31'd0, wrap}, {31'd0, exp_w});
    exp_count = exp_c;
    for (int i = 0; i < hold; i++) begin
      tick(1);
      if (step || wrap) extra++;
    end
    chk({tag, "_no_repeat"}, extra, 32'd0);
    chk({tag, "_count_held"}, {16'd0, count}, {16'd0, exp_count});
    key_n = 1'b1;
    for (int i = 0; i < STEP_TICKS + 2; i++) begin
      tick(1);
      if (step) extra++;
    end
    chk({tag, "_release_quiet"}, extra, 32'd0);
  endtask

  initial begin
    int pulses;
    resetn     = 1'b0;
    key_n      = 1'b1;
    up         = 1'b1;
    load       = 1'b0;
    load_value = 16'h0000;
    exp_count  = 16'h0000;

    tick(3);
    chk("reset_count", {16'd0, count}, 32'd0);
    chk("reset_step", {31'd0, step}, 32'd0);
    chk("reset_wrap", {31'd0, wrap}, 32'd0);
    resetn = 1'b1;
    tick(2);

`ifdef HEX_STEP_DEBOUNCE_EN
    pulses = 0;
    for (int w = 1; w <= 3; w++) begin
      key_n = 1'b0;
      for (int i = 0; i < w; i++) begin
        tick(1);
        if (step) pulses++;
      end
      key_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
        tick(1);
        if (step) pulses++;
      end
    end
    for (int i = 0; i < STEP_TICKS; i++) begin
      tick(1);
      if (step) pulses++;
    end
    chk("glitch_no_step", pulses, 32'd0);
    chk("glitch_count", {16'd0, count}, 32'd0);
`else
    key_n = 1'b0;
    tick(1);
    key_n = 1'b1;
    tick(1);
    chk("pulse_step_early", {31'd0, step}, 32'd0);
    tick(1);
    chk("pulse_step", {31'd0, step}, 32'd1);
    tick(1);
    chk("pulse_step_done", {31'd0, step}, 32'd0);
    chk("pulse_count", {16'd0, count}, 32'h0001);
    exp_count = 16'h0001;
    tick(3);
`endif

    press(1'b1, 20, exp_count + 16'h0001, 1'b0, "press_up");

    load_value = 16'hFFFF;
    load       = 1'b1;
    tick(1);
    load = 1'b0;
    chk("load_ffff", {16'd0, count}, 32'h0000_FFFF);
    chk("load_wrap", {31'd0, wrap}, 32'd0);
    exp_count = 16'hFFFF;

    press(1'b1, 2, 16'h0000, 1'b1, "wrap_up");
    press(1'b0, 2, 16'hFFFF, 1'b1, "wrap_down");
    press(1'b0, 2, 16'hFFFE, 1'b0, "dec");

    load_value = 16'h0100;
    load       = 1'b1;
    tick(1);
    load = 1'b0;
    chk("load_0100", {16'd0, count}, 32'h0000_0100);
    exp_count = 16'h0100;
    press(1'b0, 2, 16'h00FF, 1'b0, "borrow");
    press(1'b1, 2, 16'h0100, 1'b0, "carry");

    up    = 1'b1;
    key_n = 1'b0;
    tick(STEP_TICKS);
    chk("coinc_step", {31'd0, step}, 32'd1);
    load_value = 16'h1234;
    load       = 1'b1;
    tick(1);
    load = 1'b0;
    chk("coinc_count", {16'd0, count}, 32'h0000_1234);
    chk("coinc_wrap", {31'd0, wrap}, 32'd0);
    tick(6);
    chk("coinc_no_late_inc", {16'd0, count}, 32'h0000_1234);
    key_n = 1'b1;
    tick(STEP_TICKS + 2);

    key_n = 1'b0;
    tick(STEP_TICKS - 2);
    resetn = 1'b0;
    #1;
    chk("midreset_count", {16'd0, count}, 32'd0);
    chk("midreset_step", {31'd0, step}, 32'd0);
    chk("midreset_wrap", {31'd0, wrap}, 32'd0);
    tick(2);
    resetn = 1'b1;
    exp_count = 16'h0000;
    chk("release_count", {16'd0, count}, 32'd0);
    tick(STEP_TICKS - 1);
    chk("rel_step_early", {31'd0, step}, 32'd0);
    tick(1);
    chk("rel_step", {31'd0, step}, 32'd1);
    tick(1);
    chk("rel_count", {16'd0, count}, 32'h0000_0001);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (step) pulses++;
    end
    chk("rel_single_step", pulses, 32'd0);
    key_n = 1'b1;
    tick(STEP_TICKS + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hex_step_counter.md
# hex_step_counter

Upstream digit source for the seven-segment decoders on the lab board. Takes a raw active-low pushbutton, synchronizes and debounces it, and steps a multi-digit hex counter up or down by one per press. Supports synchronous parallel load. The counter value is presented as packed 4-bit nibbles; each nibble drives one `hex7seg` instance (`count[3:0]` → HEX0, `count[7:4]` → HEX1, …).

## Interface
- `DIGITS`, default 4: number of hex digits; counter width is 4*DIGITS.
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable samples required to accept a key level change (10 ms at 50 MHz); minimum 2.
- `CLOCK_50`  in  1: sole clock, rising edge.
- `resetn`  in  1: asynchronous active-low reset.
- `key_n`  in  1: raw pushbutton, active-low, asynchronous to `CLOCK_50`.
- `up`  in  1: direction, 1 = increment, 0 = decrement; sampled in the step cycle.
- `load`  in  1: synchronous load strobe.
- `load_value`  in  4*DIGITS: value loaded when `load`=1.
- `count`  out  4*DIGITS: registered counter value, nibble i = digit i.
- `step`  out  1: one-cycle pulse per accepted press.
- `wrap`  out  1: one-cycle pulse when a step crosses the modulus boundary.

## Operation
- Synchronizer: two flops on `key_n`, reset to 1 (released).
- Debounce FSM, states RELEASED (reset state) and PRESSED, plus a stability counter of width $clog2(DEBOUNCE_CYCLES).
  - Counter clears whenever the synced sample equals the level of the current state.
  - Counter increments when the sample differs.
  - When the sample differs and the counter equals DEBOUNCE_CYCLES-1, the state flips and the counter clears.
- RELEASED→PRESSED registers `step`=1 for exactly one cycle. PRESSED→RELEASED produces no pulse.
- Holding the key produces a single step; no auto-repeat.
- Counter update priority:
  - `load`=1: `count` ← `load_value`. Any coincident step is dropped, and `wrap` stays 0.
  - Otherwise, on `step`=1 with `up`=1: `count` ← `count`+1 mod 16^DIGITS. `wrap`=1 when the old value is all-F.
  - Otherwise, on `step`=1 with `up`=0: `count` ← `count`-1 mod 16^DIGITS. `wrap`=1 when the old value is 0.
- Arithmetic is full-width binary, not BCD. Each nibble is a true hex digit 0–F.
- Reset values: `count`=0, `step`=0, `wrap`=0, FSM=RELEASED, stability counter=0, synchronizer flops=1.
- Reset mid-press: all state returns to reset values. A key still held after reset release is debounced afresh and yields exactly one step.
- Glitches shorter than DEBOUNCE_CYCLES samples never change state.

## Timing
- `key_n` falls before edge E and stays low: synced low after edge E+1.
- FSM enters PRESSED and `step` goes high after edge E+1+DEBOUNCE_CYCLES. `step` is high for that one cycle.
- `count` and `wrap` update on the next edge, E+2+DEBOUNCE_CYCLES. `wrap` is high for that one cycle.
- `load` asserted before edge L: `count` equals `load_value` after edge L (1-cycle latency).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `HEX_STEP_DEBOUNCE_EN` defined: debounce FSM and stability counter are built as described above.
- Macro undefined: the stability counter is removed, the FSM level follows the synchronized sample directly, and `step` pulses the cycle after the synced falling edge (latency 2 edges + 1 cycle). Intended for simulation and for externally debounced inputs; `DEBOUNCE_CYCLES` is ignored.

## Structure
- Shared package `hex_disp_pkg`: debounce state encoding (RELEASED=1'b0, PRESSED=1'b1), `NIBBLE_W`=4, default `DEBOUNCE_CYCLES`.
- One sub-module, `key_debounce`: synchronizer + FSM + stability counter, outputs `step`.
- The top holds the counter, load mux and wrap logic.

## Test plan
All scenarios use `DIGITS`=4, `DEBOUNCE_CYCLES`=4, macro defined.
- Hold `key_n` low for 20 cycles with `up`=1 from reset → exactly one `step` pulse at edge E+5, and `count`=0x0001 at E+6.
- `key_n` low-pulses of 1, 2 and 3 cycles separated by 5 high cycles → no `step`, and `count` stays 0x0000.
- `load`=1 with `load_value`=0xFFFF, then one press with `up`=1 → `count`=0x0000 with one `wrap` pulse. A following press with `up`=0 → `count`=0xFFFF with one `wrap` pulse.
- `load` asserted in the same cycle as a `step` pulse, `load_value`=0x1234 → `count`=0x1234 and `wrap`=0. No later increment occurs from that press.
- Assert `resetn` low mid-debounce (after 2 stable low samples) while the key is held, then release reset → all outputs 0. One step occurs DEBOUNCE_CYCLES+2 edges after reset release, giving `count`=0x0001.
- Macro undefined: single 1-cycle low pulse on `key_n` → `step` pulses, and `count` increments 3 edges after the pulse.
